// File: rtl/laser_collision.sv
// rtl/laser_collision.sv - laser versus invader-grid collision scanner with alive bitmap
module laser_collision #(
    parameter int COLS      = 6,
    parameter int ROWS      = 5,
    parameter int INV_W     = 32,
    parameter int INV_H     = 24,
    parameter int COL_PITCH = 48,
    parameter int ROW_PITCH = 36,
    parameter int PROJ_W    = 4,
    parameter int PROJ_H    = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 frame,
    input  logic                 laser_active,
    input  logic [9:0]           laser_x,
    input  logic [9:0]           laser_y,
    input  logic [9:0]           grid_x,
    input  logic [9:0]           grid_y,
    input  logic                 new_wave,
    output logic [COLS-1:0]      invader_collision,
    output logic [ROWS*COLS-1:0] alive,
    output logic                 score_inc,
    output logic [2:0]           hit_row,
    output logic                 all_dead
);

    localparam int NCELL = ROWS * COLS;
    localparam int IDX_W = (NCELL > 1) ? $clog2(NCELL) : 1;
    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        HOLD
    } state_t;

    state_t             state_q;
    logic [ROW_W-1:0]   row_q;
    logic [COL_W-1:0]   col_q;
    logic [COLS-1:0]    coll_q;
    logic [NCELL-1:0]   alive_q;
    logic               score_q;
    logic [2:0]         hit_row_q;

    // Candidate geometry, widened to 11 bits so edge sums cannot wrap
    logic [10:0]        col_off_d;
    logic [10:0]        row_off_d;
    logic [10:0]        inv_x_d;
    logic [10:0]        inv_y_d;
    logic [10:0]        lx_d;
    logic [10:0]        ly_d;
    logic               overlap_x_d;
    logic               overlap_y_d;
    logic [IDX_W-1:0]   idx_d;
    logic               hit_d;
    logic               last_col_d;
    logic               last_d;
    logic [COLS-1:0]    onehot_d;

    // Evaluate the current scan candidate against the laser box
    always_comb begin
        col_off_d   = 11'(col_q) * 11'(COL_PITCH);
        row_off_d   = 11'(row_q) * 11'(ROW_PITCH);
        inv_x_d     = {1'b0, grid_x} + col_off_d;
        inv_y_d     = {1'b0, grid_y} + row_off_d;
        lx_d        = {1'b0, laser_x};
        ly_d        = {1'b0, laser_y};
        // Strict comparisons: boxes that only share an edge do not collide
        overlap_x_d = (lx_d < inv_x_d + 11'(INV_W)) &&
                      (lx_d + 11'(PROJ_W) > inv_x_d);
        overlap_y_d = (ly_d < inv_y_d + 11'(INV_H)) &&
                      (ly_d + 11'(PROJ_H) > inv_y_d);
        idx_d       = IDX_W'(row_q) * IDX_W'(COLS) + IDX_W'(col_q);
        hit_d       = alive_q[idx_d] && overlap_x_d && overlap_y_d;
        last_col_d  = (col_q == COL_W'(COLS - 1));
        // Rows run bottom to top, so row 0 / last column ends the scan
        last_d      = (row_q == '0) && last_col_d;
        onehot_d    = COLS'(1) << col_q;
    end

    // Scan FSM with registered outputs; new_wave overrides any same-cycle hit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            row_q     <= '0;
            col_q     <= '0;
            coll_q    <= '0;
            alive_q   <= '1;
            score_q   <= 1'b0;
            hit_row_q <= 3'd0;
        end else begin
            score_q <= 1'b0;
            if (new_wave) begin
                alive_q <= '1;
                coll_q  <= '0;
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (frame && laser_active) begin
                            state_q <= SCAN;
                            row_q   <= ROW_W'(ROWS - 1);
                            col_q   <= '0;
                        end
                    end
                    SCAN: begin
                        if (!laser_active) begin
                            // Laser vanished mid-scan: drop the frame, record nothing
                            state_q <= IDLE;
                        end else if (hit_d) begin
                            alive_q[idx_d] <= 1'b0;
                            coll_q         <= onehot_d;
                            hit_row_q      <= 3'(row_q);
                            score_q        <= 1'b1;
                            state_q        <= HOLD;
                        end else if (last_d) begin
                            state_q <= IDLE;
                        end else if (last_col_d) begin
                            col_q <= '0;
                            row_q <= row_q - ROW_W'(1);
                        end else begin
                            col_q <= col_q + COL_W'(1);
                        end
                    end
                    HOLD: begin
                        // Keep the collision visible until the laser stage retires the shot
                        if (!laser_active) begin
                            coll_q  <= '0;
                            state_q <= IDLE;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign invader_collision = coll_q;
    assign alive             = alive_q;
    assign score_inc         = score_q;
    assign hit_row           = hit_row_q;
    assign all_dead          = ~|alive_q;

endmodule

// File: tb/tb_laser_collision.sv
// tb/tb_laser_collision.sv - scoreboard bench for laser_collision
module tb_laser_collision;

    localparam int COLS  = 6;
    localparam int ROWS  = 5;
    localparam int NCELL = 30;
    localparam int GX    = 100;
    localparam int GY    = 60;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame = 1'b0;
    logic        laser_active = 1'b0;
    logic [9:0]  laser_x = '0;
    logic [9:0]  laser_y = '0;
    logic [9:0]  grid_x = 10'(GX);
    logic [9:0]  grid_y = 10'(GY);
    logic        new_wave = 1'b0;
    logic [5:0]  invader_collision;
    logic [29:0] alive;
    logic        score_inc;
    logic [2:0]  hit_row;
    logic        all_dead;

    laser_collision dut (
        .clk               (clk),
        .rst               (rst),
        .frame             (frame),
        .laser_active      (laser_active),
        .laser_x           (laser_x),
        .laser_y           (laser_y),
        .grid_x            (grid_x),
        .grid_y            (grid_y),
        .new_wave          (new_wave),
        .invader_collision (invader_collision),
        .alive             (alive),
        .score_inc         (score_inc),
        .hit_row           (hit_row),
        .all_dead          (all_dead)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [5:0]  coll;
        logic [2:0]  row;
        logic [29:0] alive;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic [29:0] alive_m = '1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int at, input logic [5:0] coll, input logic [2:0] row);
        exp_t e;
        e.cyc   = at;
        e.coll  = coll;
        e.row   = row;
        e.alive = alive_m;
        sb_q.push_back(e);
    endtask

    // Monitor: every score_inc pulse must match the oldest expected hit
    always @(negedge clk) begin
        if (!rst && score_inc) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_score_inc: got pulse expected none (cyc %0d, coll %b)",
                         cyc, invader_collision);
            end else begin
                mon_e = sb_q.pop_front();
                chk("hit_cycle", cyc, mon_e.cyc);
                chk("hit_coll", {26'd0, invader_collision}, {26'd0, mon_e.coll});
                chk("hit_row", {29'd0, hit_row}, {29'd0, mon_e.row});
                chk("hit_alive", {2'd0, alive}, {2'd0, mon_e.alive});
                chk("hit_all_dead", {31'd0, all_dead}, {31'd0, (mon_e.alive == '0)});
            end
        end
    end

    // One frame's worth of scan, then the laser stage retires the shot
    task automatic shot(input int lx, input int ly, input bit hit, input int k, input int r, input int c);
        int c0;
        @(posedge clk); #1;
        c0 = cyc;
        laser_x = 10'(lx);
        laser_y = 10'(ly);
        laser_active = 1'b1;
        frame = 1'b1;
        if (hit) begin
            alive_m[r*COLS+c] = 1'b0;
            push(c0 + 2 + k, 6'(1 << c), 3'(r));
        end
        @(posedge clk); #1;
        frame = 1'b0;
        repeat (32) @(posedge clk);
        #1;
        chk("hold_coll", {26'd0, invader_collision}, hit ? 32'(1 << c) : 32'd0);
        laser_active = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("release_coll", {26'd0, invader_collision}, 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL timeout: got no finish expected finish by 400000");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks + 1);
        $fatal(1);
    end

    initial begin
        int c0;
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_coll", {26'd0, invader_collision}, 32'd0);
        chk("rst_score", {31'd0, score_inc}, 32'd0);
        chk("rst_hit_row", {29'd0, hit_row}, 32'd0);
        chk("rst_alive", {2'd0, alive}, 32'h3FFF_FFFF);
        chk("rst_all_dead", {31'd0, all_dead}, 32'd0);
        rst = 1'b0;

        // Edge-touch misses around row 4 / col 2 (x 196..228, y 204..228)
        shot(228, 210, 1'b0, 0, 0, 0);
        shot(192, 210, 1'b0, 0, 0, 0);
        shot(200, 192, 1'b0, 0, 0, 0);
        shot(200, 228, 1'b0, 0, 0, 0);

        // Direct hit: row 4 col 2, bit 26, candidate 2
        shot(200, 210, 1'b1, 2, 4, 2);
        // One-pixel overlaps: right/bottom edge of col 3, left/top edge of col 4
        shot(275, 225, 1'b1, 3, 4, 3);
        shot(289, 193, 1'b1, 4, 4, 4);
        // Scan order: row 3 col 0 is candidate 6, row 0 col 5 is candidate 29
        shot(110, 180, 1'b1, 6, 3, 0);
        shot(350, 66, 1'b1, 29, 0, 5);

        // Hold release: row 4 col 0, laser stays up 5 cycles after the hit
        @(posedge clk); #1;
        laser_x = 10'd110; laser_y = 10'd210; laser_active = 1'b1; frame = 1'b1;
        alive_m[24] = 1'b0;
        push(cyc + 2, 6'b000001, 3'd4);
        @(posedge clk); #1;
        frame = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("hold_high", {26'd0, invader_collision}, 32'h01);
        end
        laser_active = 1'b0;
        #3;
        chk("hold_after_drop", {26'd0, invader_collision}, 32'h01);
        @(posedge clk); #1;
        chk("hold_cleared", {26'd0, invader_collision}, 32'd0);

        // Scan length: frame held across end of a 30-candidate miss; only the IDLE sample counts
        @(posedge clk); #1;
        c0 = cyc;
        laser_x = 10'd228; laser_y = 10'd210; laser_active = 1'b1; frame = 1'b1;
        @(posedge clk); #1;
        frame = 1'b0;
        repeat (29) @(posedge clk);
        #1;
        laser_x = 10'd150;
        frame = 1'b1;
        alive_m[25] = 1'b0;
        push(c0 + 34, 6'b000010, 3'd4);
        repeat (3) @(posedge clk);
        #1;
        frame = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("scanlen_coll", {26'd0, invader_collision}, 32'h02);
        laser_active = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Abort: laser drops during candidate 0; row 0 col 0 (candidate 24) must survive
        laser_x = 10'd110; laser_y = 10'd66; laser_active = 1'b1; frame = 1'b1;
        @(posedge clk); #1;
        frame = 1'b0;
        laser_active = 1'b0;
        repeat (32) @(posedge clk);
        #1;
        chk("abort_coll", {26'd0, invader_collision}, 32'd0);
        chk("abort_alive", {2'd0, alive}, {2'd0, alive_m});

        // new_wave on the cycle the row 0 col 0 hit would register
        laser_active = 1'b1; frame = 1'b1;
        @(posedge clk); #1;
        frame = 1'b0;
        repeat (24) @(posedge clk);
        #1;
        new_wave = 1'b1;
        @(posedge clk); #1;
        new_wave = 1'b0;
        alive_m = '1;
        chk("nw_alive", {2'd0, alive}, 32'h3FFF_FFFF);
        chk("nw_coll", {26'd0, invader_collision}, 32'd0);
        repeat (8) @(posedge clk);
        #1;
        chk("nw_coll_later", {26'd0, invader_collision}, 32'd0);
        laser_active = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Asynchronous reset while holding a collision
        laser_x = 10'd200; laser_y = 10'd210; laser_active = 1'b1; frame = 1'b1;
        alive_m[26] = 1'b0;
        push(cyc + 2 + 2, 6'b000100, 3'd4);
        @(posedge clk); #1;
        frame = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        chk("prerst_coll", {26'd0, invader_collision}, 32'h04);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_coll", {26'd0, invader_collision}, 32'd0);
        chk("arst_score", {31'd0, score_inc}, 32'd0);
        chk("arst_hit_row", {29'd0, hit_row}, 32'd0);
        chk("arst_alive", {2'd0, alive}, 32'h3FFF_FFFF);
        alive_m = '1;
        @(posedge clk); #1;
        rst = 1'b0;
        laser_active = 1'b0;

        // Clear the whole grid, centre of each invader in turn
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (r == ROWS - 1 && c == COLS - 1)
                    chk("not_yet_dead", {31'd0, all_dead}, 32'd0);
                shot(GX + c*48 + 10, GY + r*36 + 6, 1'b1, (ROWS - 1 - r)*COLS + c, r, c);
            end
        end
        chk("all_dead", {31'd0, all_dead}, 32'd1);
        chk("all_dead_alive", {2'd0, alive}, 32'd0);
        shot(200, 210, 1'b0, 0, 0, 0);
        shot(110, 66, 1'b0, 0, 0, 0);

        chk("sb_empty", sb_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/laser_collision.md
LASER_COLLISION -- requirements
Module: laser_collision

Interface
REQ-001 Parameter COLS, 6, invader grid columns; one bit per column in invader_collision.
REQ-002 Parameter ROWS, 5, invader grid rows.
REQ-003 Parameters INV_W 32 and INV_H 24, scaled invader sprite width and height in pixels.
REQ-004 Parameters COL_PITCH 48 and ROW_PITCH 36, pixel spacing between adjacent invader top-left corners.
REQ-005 Parameters PROJ_W 4 and PROJ_H 12, scaled laser width and height in pixels.
REQ-006 clk  in  1  system clock; one clock only.
REQ-007 rst  in  1  reset, asynchronous, active-high.
REQ-008 frame  in  1  one-cycle pulse at the start of the blanking interval.
REQ-009 laser_active  in  1  laser-present flag from the laser stage.
REQ-010 laser_x, laser_y  in  10 each  top-left corner of the laser.
REQ-011 grid_x, grid_y  in  10 each  top-left corner of invader (row 0, col 0).
REQ-012 new_wave  in  1  one-cycle pulse that restores all invaders.
REQ-013 invader_collision  out  COLS  one-hot column of the invader hit; feeds the laser stage.
REQ-014 alive  out  ROWS*COLS  alive bitmap; bit index = row*COLS+col.
REQ-015 score_inc  out  1  one-cycle pulse per destroyed invader.
REQ-016 hit_row  out  3  row of the most recent hit.
REQ-017 all_dead  out  1  high when alive == 0.

Function
REQ-018 States: IDLE, SCAN, HOLD.
REQ-019 IDLE -> SCAN on frame && laser_active; frame with laser_active low is ignored.
REQ-020 SCAN order: one candidate per cycle. Rows run ROWS-1 down to 0 (bottom row first). Columns within each row run 0 to COLS-1.
REQ-021 The first candidate is evaluated in the cycle after frame. Candidate k is evaluated in cycle k+1.
REQ-022 Candidate box: inv_x = grid_x + col*COL_PITCH; inv_y = grid_y + row*ROW_PITCH.
REQ-023 All position arithmetic is 11-bit unsigned, so sums never wrap.
REQ-024 Hit condition, all four terms true:
  - alive[idx] = 1
  - laser_x < inv_x+INV_W
  - laser_x+PROJ_W > inv_x
  - laser_y < inv_y+INV_H and laser_y+PROJ_H > inv_y
  Edges that only touch are a miss.
REQ-025 On the first hit, in the cycle after evaluation:
  - clear alive[idx]
  - set invader_collision to the one-hot column
  - load hit_row
  - pulse score_inc for exactly one cycle
  - go to HOLD
  Remaining candidates are not evaluated, so at most one kill per frame.
REQ-026 SCAN with no hit after ROWS*COLS candidates -> IDLE; outputs unchanged.
REQ-027 HOLD: invader_collision stays asserted until laser_active is sampled low. It clears on the following cycle, then the FSM enters IDLE.
REQ-028 laser_active low during SCAN: abort to IDLE next cycle; no hit is recorded.
REQ-029 frame during SCAN or HOLD is ignored.
REQ-030 new_wave in any state:
  - alive set to all ones
  - invader_collision cleared
  - FSM to IDLE
  - no score_inc
  new_wave has priority over a same-cycle hit.
REQ-031 all_dead is combinational from alive; when all_dead is high, SCAN still runs but cannot hit.
REQ-032 Laser inputs and grid inputs are sampled each SCAN cycle. They must not change mid-scan; the upstream stages update only on frame.

Reset
REQ-033 rst asserted:
  - state IDLE
  - invader_collision = 0, score_inc = 0, hit_row = 0
  - alive = all ones, so all_dead = 0
REQ-034 rst takes effect immediately, independent of clk, and aborts SCAN or HOLD.

Verification
REQ-035 Direct hit: grid (100,60), laser (200,210), active, frame. Expected:
  - invader_collision = 000100 two cycles after frame+candidate latency
  - alive[26] = 0, hit_row = 4
  - one score_inc pulse
REQ-036 Bottom-first priority: laser overlaps row 4 and row 3 of col 0. Only bit 24 clears, and invader_collision = 000001.
REQ-037 Miss and edge: laser_x = 228 with grid_x = 100 touches the col 2 right edge (196+32). No collision, FSM back to IDLE after 30 scan cycles.
REQ-038 HOLD release: collision asserted, laser_active stays high 5 cycles then drops. invader_collision stays high until one cycle after the drop, then 0.
REQ-039 Abort cases:
  - laser_active drops mid-scan: no hit.
  - new_wave in the same cycle as a hit: alive all ones, no score_inc.
  - rst mid-HOLD: outputs cleared asynchronously.
REQ-040 All dead: clear all 30 invaders by successive hits. all_dead rises with the last hit; later frames produce no collisions.
